// File: rtl/bin_to_thermo_ramp.sv
// bin_to_thermo_ramp: registered binary-to-thermometer decoder that
// slews the thermometer output one segment per step toward a target.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   in_valid - target code present
//   in_ready - block can accept a target
//   in_bin   - target level, 0..THERMO_W
//   t        - registered thermometer code (t[j] = j < level)
//   level    - registered count of ones on t
//   busy     - ramp in progress
//   done     - one-cycle pulse when t reaches the accepted target
//
// Optional build macro: THERMO_RETARGET_EN
//   When defined, targets are also accepted mid-ramp and replace the
//   pending target without disturbing the step cadence.
module bin_to_thermo_ramp #(
    parameter int BIN_W = 3,
    parameter int STEP_DIV = 1,
    localparam int THERMO_W = 2**BIN_W - 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    in_bin,
    output logic [THERMO_W-1:0] t,
    output logic [BIN_W-1:0]    level,
    output logic                busy,
    output logic                done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RAMP = 1'b1;

    localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

    logic [0:0]          state;
    logic [0:0]          state_n;
    logic [BIN_W-1:0]    target;
    logic [BIN_W-1:0]    target_n;
    logic [BIN_W-1:0]    level_n;
    logic [THERMO_W-1:0] t_n;
    logic [7:0]          div_cnt;
    logic [7:0]          div_n;
    logic                done_n;

    logic                accept;
    logic                step_now;
    logic [BIN_W-1:0]    eff_target;
    logic [BIN_W-1:0]    stepped;
    logic                hit;
    logic                start;
    logic                step;
    logic                hold;

`ifdef THERMO_RETARGET_EN
    assign in_ready = 1'b1;
`else
    assign in_ready = (state == IDLE);
`endif

    assign busy     = (state == RAMP);
    assign accept   = in_valid && in_ready;
    assign step_now = (state == RAMP) && (div_cnt == DIV_LAST);

    // A target accepted on this edge steers the step taken on this edge.
    assign eff_target = accept ? in_bin : target;

    // Only used when eff_target != level, so it never wraps.
    assign stepped = (eff_target > level) ? level + BIN_W'(1)
                                          : level - BIN_W'(1);

    // Mutually exclusive actions for this edge.
    assign hit   = accept && (in_bin == level);
    assign start = accept && (state == IDLE) && !hit;
    assign step  = step_now && !hit;
    assign hold  = (state == RAMP) && !step_now && !hit;

    always_comb begin
        state_n  = state;
        target_n = accept ? in_bin : target;
        level_n  = level;
        div_n    = div_cnt;
        done_n   = 1'b0;
        unique case (1'b1)
            hit: begin
                state_n = IDLE;
                div_n   = 8'd0;
                done_n  = 1'b1;
            end
            start: begin
                state_n = RAMP;
                div_n   = 8'd0;
            end
            step: begin
                level_n = stepped;
                div_n   = 8'd0;
                if (stepped == eff_target) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            hold: begin
                div_n = div_cnt + 8'd1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        t_n = '0;
        for (int j = 0; j < THERMO_W; j++) begin
            t_n[j] = (level_n > BIN_W'(j));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            target  <= '0;
            level   <= '0;
            t       <= '0;
            div_cnt <= 8'd0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            target  <= target_n;
            level   <= level_n;
            t       <= t_n;
            div_cnt <= div_n;
            done    <= done_n;
        end
    end

endmodule
